// File: rtl/dct4_input_framer.sv
// 4-sample block framer feeding the 4-point DCT: collects samples over valid/ready,
// double-buffers blocks (collector + output register) and registers the first butterfly stage.
module dct4_input_framer #(
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_sof_i,
  output logic          blk_valid_o,
  input  logic          blk_ready_i,
  output logic [DW-1:0] x0_o,
  output logic [DW-1:0] x1_o,
  output logic [DW-1:0] x2_o,
  output logic [DW-1:0] x3_o,
  output logic [DW:0]   a0_sum_o,
  output logic [DW:0]   b0_diff_o,
  output logic [DW:0]   a1_sum_o,
  output logic [DW:0]   b1_diff_o,
  output logic [7:0]    blk_count_o,
  output logic          err_resync_o
);

  logic [2:0]    cnt_q, cnt_d;
  logic [DW-1:0] slot_q [4];
  logic [DW-1:0] slot_d [4];
  logic          err_q, err_d;

  logic          blk_valid_q;
  logic [DW-1:0] x_q [4];
  logic [DW:0]   a0_q, b0_q, a1_q, b1_q;
  logic [7:0]    blk_count_q;

  logic free, accept, xfer;

  function automatic logic [DW:0] sx(input logic [DW-1:0] v);
    return {v[DW-1], v};
  endfunction

  assign free       = !blk_valid_q || blk_ready_i;
  assign in_ready_o = (cnt_q != 3'd4) || free;
  assign accept     = in_valid_i && in_ready_o;
  assign xfer       = (cnt_q == 3'd4) && free;

  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q;
    err_d  = 1'b0;
    if (xfer) cnt_d = '0;
    if (accept) begin
      // cnt==4 with an accept implies a transfer this cycle, so the default
      // branch only ever sees cnt in 0..3 and cannot index past slot 3.
      if (xfer) begin
        slot_d[0] = in_data_i;
        cnt_d     = 3'd1;
      end else if (in_sof_i && (cnt_q != 3'd0)) begin
        slot_d[0] = in_data_i;
        cnt_d     = 3'd1;
        err_d     = 1'b1;
      end else begin
        slot_d[cnt_q[1:0]] = in_data_i;
        cnt_d              = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) slot_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      slot_q <= slot_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blk_valid_q <= 1'b0;
      blk_count_q <= '0;
      a0_q        <= '0;
      b0_q        <= '0;
      a1_q        <= '0;
      b1_q        <= '0;
      for (int unsigned i = 0; i < 4; i++) x_q[i] <= '0;
    end else if (xfer) begin
      blk_valid_q <= 1'b1;
      blk_count_q <= blk_count_q + 8'd1;
      x_q         <= slot_q;
      a0_q        <= sx(slot_q[0]) + sx(slot_q[3]);
      b0_q        <= sx(slot_q[0]) - sx(slot_q[3]);
      a1_q        <= sx(slot_q[1]) + sx(slot_q[2]);
      b1_q        <= sx(slot_q[1]) - sx(slot_q[2]);
    end else if (blk_valid_q && blk_ready_i) begin
      blk_valid_q <= 1'b0;
    end
  end

  assign blk_valid_o  = blk_valid_q;
  assign x0_o         = x_q[0];
  assign x1_o         = x_q[1];
  assign x2_o         = x_q[2];
  assign x3_o         = x_q[3];
  assign a0_sum_o     = a0_q;
  assign b0_diff_o    = b0_q;
  assign a1_sum_o     = a1_q;
  assign b1_diff_o    = b1_q;
  assign blk_count_o  = blk_count_q;
  assign err_resync_o = err_q;

endmodule
